tl_ul_ram_responder: RTL and testbench

- TileLink-UL manager (responder) terminating the client-side A/D link that bank-binding and pass-through adapters forward.
- Accepts single-beat Get, PutFullData and PutPartialData on channel A, backed by a register-file RAM.
- Returns AccessAck or AccessAckData on channel D through a small response FIFO.
- Used as the leaf memory/scratchpad behind the RV32 system bus fragment: 32-bit data, 2-bit source.

---
 rtl/tl_ul_ram_responder.sv | 167 ++++++++++++++++
 tb/tb_tl_ul_ram_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_ram_responder.sv
`default_nettype none
// ============================================================================
// tl_ul_ram_responder : TileLink-UL single-beat RAM manager with response FIFO
// Revision: 1.0
// ============================================================================
module tl_ul_ram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          ADDR_WORDS = 64,
    parameter int          RESP_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [1:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [3:0]  auto_in_a_bits_mask,
    input  logic [31:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [1:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_denied,
    output logic [31:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int          AW           = $clog2(ADDR_WORDS);
    localparam int          PW           = $clog2(RESP_DEPTH);
    localparam int          IW           = (PW > 0) ? PW : 1;
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * ADDR_WORDS);
    localparam logic [PW:0] FULL_XOR     = (PW + 1)'(1 << PW);

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [1:0]  source;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } resp_t;

    logic [31:0] mem [ADDR_WORDS];
    resp_t       fifo [RESP_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic        is_put;
    logic        is_get;
    logic        supported;
    logic        in_range;
    logic        misaligned;
    logic        denied;
    resp_t       new_resp;
    resp_t       head;
    logic        unused_param;

    assign unused_param = ^auto_in_a_bits_param;

    generate
        if (RESP_DEPTH == 1) begin : g_idx_single
            assign wr_idx = 1'b0;
            assign rd_idx = 1'b0;
        end else begin : g_idx_multi
            assign wr_idx = wr_ptr[IW-1:0];
            assign rd_idx = rd_ptr[IW-1:0];
        end
    endgenerate

    assign full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign empty = (wr_ptr == rd_ptr);

    // A request presented while reset is held is never committed.
    assign push = auto_in_a_valid && !full && !reset;
    assign pop  = !empty && auto_in_d_ready;

    assign offset    = auto_in_a_bits_address - BASE_ADDR;
    assign idx       = offset[AW+1:2];
    assign is_put    = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
    assign is_get    = (auto_in_a_bits_opcode == 3'd4);
    assign supported = is_put || is_get;
    assign in_range  = (auto_in_a_bits_address >= BASE_ADDR) && (offset < WINDOW_BYTES);

    always_comb begin
        misaligned = 1'b0;
        case (auto_in_a_bits_size)
            3'd1:    misaligned = auto_in_a_bits_address[0];
            3'd2:    misaligned = |auto_in_a_bits_address[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign denied = !supported || (auto_in_a_bits_size > 3'd2) || !in_range || misaligned
                    || (is_put && auto_in_a_bits_corrupt);

    always_comb begin
        new_resp        = '0;
        new_resp.opcode = is_get ? 3'd1 : 3'd0;
        new_resp.size   = auto_in_a_bits_size;
        new_resp.source = auto_in_a_bits_source;
        new_resp.denied = denied;
        if (is_get) begin
            // A refused data response must also flag its data as corrupt.
            if (denied) begin
                new_resp.corrupt = 1'b1;
            end else begin
                new_resp.data = mem[idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && is_put && !denied) begin
            for (int b = 0; b < 4; b++) begin
                if (auto_in_a_bits_mask[b]) begin
                    mem[idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo[wr_idx] <= new_resp;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset, so an empty FIFO presents all-zero D fields.
    assign head = empty ? '0 : fifo[rd_idx];

    assign auto_in_a_ready        = !full;
    assign auto_in_d_valid        = !empty;
    assign auto_in_d_bits_opcode  = head.opcode;
    assign auto_in_d_bits_size    = head.size;
    assign auto_in_d_bits_source  = head.source;
    assign auto_in_d_bits_denied  = head.denied;
    assign auto_in_d_bits_data    = head.data;
    assign auto_in_d_bits_corrupt = head.corrupt;

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_ram_responder.sv
`default_nettype none
// ============================================================================
// tb_tl_ul_ram_responder : table plus sequences, scoreboarded D responses
// Revision: 1.0
// ============================================================================
module tb_tl_ul_ram_responder;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [1:0]  source;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } resp_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [1:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
        resp_t       exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_ready;
    logic        a_valid = 1'b0;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [2:0]  a_size = '0;
    logic [1:0]  a_source = '0;
    logic [31:0] a_address = '0;
    logic [3:0]  a_mask = '0;
    logic [31:0] a_data = '0;
    logic        a_corrupt = 1'b0;
    logic        d_ready = 1'b0;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [1:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    int    checks = 0;
    int    failures = 0;
    resp_t exp_q[$];
    resp_t mon_act;
    resp_t mon_exp;
    vec_t  vecs[20];

    tl_ul_ram_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                                input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                                input logic cor, input logic [2:0] eop, input logic eden,
                                input logic [31:0] edata, input logic ecor);
        vec_t v;
        v.op = op; v.size = size; v.src = src; v.addr = addr;
        v.mask = mask; v.data = data; v.corrupt = cor;
        v.exp = '{opcode: eop, size: size, source: src, denied: eden, data: edata, corrupt: ecor};
        return v;
    endfunction

    function automatic resp_t rsp(input logic [2:0] op, input logic [1:0] src, input logic [31:0] data);
        return '{opcode: op, size: 3'd2, source: src, denied: 1'b0, data: data, corrupt: 1'b0};
    endfunction

    // Scoreboard: every D handshake is matched against the oldest expectation.
    always @(negedge clock) begin
        if (!reset && d_valid && d_ready) begin
            mon_act = '{opcode: d_opcode, size: d_size, source: d_source, denied: d_denied,
                        data: d_data, corrupt: d_corrupt};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d_unexpected actual=%h required=no_response", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                check("d_resp", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    task automatic drive(input vec_t v);
        a_valid = 1'b1; a_opcode = v.op; a_size = v.size; a_source = v.src;
        a_address = v.addr; a_mask = v.mask; a_data = v.data; a_corrupt = v.corrupt;
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        drive(v);
        @(negedge clock);
        while (!a_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("a_accept", 64'(a_ready), 64'd1);
        if (a_ready) exp_q.push_back(v.exp);
        @(posedge clock); #1;
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clock);
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(3'd0, 3'd2, 2'd1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
        vecs[1]  = mk(3'd4, 3'd2, 2'd2, 32'h8000_0010, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        vecs[2]  = mk(3'd1, 3'd2, 2'd0, 32'h8000_0010, 4'h2, 32'h0000_5500, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
        vecs[3]  = mk(3'd4, 3'd2, 2'd3, 32'h8000_0010, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD_55EF, 1'b0);
        vecs[4]  = mk(3'd4, 3'd2, 2'd1, 32'h8000_0100, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0, 1'b1);
        vecs[5]  = mk(3'd4, 3'd3, 2'd2, 32'h8000_0010, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0, 1'b1);
        vecs[6]  = mk(3'd2, 3'd2, 2'd0, 32'h8000_0010, 4'hF, 32'h1234_5678, 1'b0, 3'd0, 1'b1, 32'h0, 1'b0);
        vecs[7]  = mk(3'd4, 3'd2, 2'd1, 32'h8000_0010, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD_55EF, 1'b0);
        vecs[8]  = mk(3'd4, 3'd2, 2'd2, 32'h8000_0012, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0, 1'b1);
        vecs[9]  = mk(3'd4, 3'd1, 2'd3, 32'h8000_0012, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hDEAD_55EF, 1'b0);
        vecs[10] = mk(3'd0, 3'd2, 2'd0, 32'h8000_0014, 4'hF, 32'hAAAA_5555, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
        vecs[11] = mk(3'd0, 3'd2, 2'd1, 32'h8000_0014, 4'hF, 32'h1111_1111, 1'b1, 3'd0, 1'b1, 32'h0, 1'b0);
        vecs[12] = mk(3'd4, 3'd2, 2'd2, 32'h8000_0014, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hAAAA_5555, 1'b0);
        vecs[13] = mk(3'd4, 3'd2, 2'd3, 32'h7FFF_FFFC, 4'hF, 32'h0,        1'b0, 3'd1, 1'b1, 32'h0, 1'b1);
        vecs[14] = mk(3'd0, 3'd2, 2'd0, 32'h8000_00FC, 4'hF, 32'hCAFE_F00D, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
        vecs[15] = mk(3'd4, 3'd2, 2'd1, 32'h8000_00FC, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'hCAFE_F00D, 1'b0);
        vecs[16] = mk(3'd0, 3'd2, 2'd2, 32'h8000_0100, 4'hF, 32'h7777_7777, 1'b0, 3'd0, 1'b1, 32'h0, 1'b0);
        vecs[17] = mk(3'd6, 3'd2, 2'd3, 32'h8000_0010, 4'hF, 32'h0,        1'b0, 3'd0, 1'b1, 32'h0, 1'b0);
        vecs[18] = mk(3'd1, 3'd0, 2'd0, 32'h8000_0013, 4'h8, 32'h9900_0000, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
        vecs[19] = mk(3'd4, 3'd2, 2'd1, 32'h8000_0010, 4'hF, 32'h0,        1'b0, 3'd1, 1'b0, 32'h99AD_55EF, 1'b0);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_a_ready", 64'(a_ready), 64'd1);
        check("reset_d_valid", 64'(d_valid), 64'd0);
        check("reset_d_bits", 64'({d_opcode, d_size, d_source, d_denied, d_data, d_corrupt}), 64'd0);
        reset = 1'b0;
        d_ready = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 20; i++) begin
            send(vecs[i]);
        end
        drain();

        // Backpressure: two accepts fill the FIFO, third waits with valid held
        d_ready = 1'b0;
        for (int s = 0; s < 3; s++) exp_q.push_back(rsp(3'd1, 2'(s), 32'h99AD_55EF));
        drive(mk(3'd4, 3'd2, 2'd0, 32'h8000_0010, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 32'h0, 1'b0));
        check("bp_ready_first", 64'(a_ready), 64'd1);
        @(posedge clock); #1;
        check("bp_latency", 64'(d_valid), 64'd1);
        check("bp_ready_second", 64'(a_ready), 64'd1);
        a_source = 2'd1;
        @(posedge clock); #1;
        check("bp_full", 64'(a_ready), 64'd0);
        a_source = 2'd2;
        repeat (2) @(posedge clock);
        #1;
        check("bp_still_full", 64'(a_ready), 64'd0);
        check("bp_hold_src", 64'(d_source), 64'd0);
        check("bp_hold_data", 64'(d_data), 64'h99AD_55EF);
        d_ready = 1'b1;
        @(posedge clock); #1;
        d_ready = 1'b0;
        check("bp_ready_back", 64'(a_ready), 64'd1);
        @(posedge clock); #1;
        a_valid = 1'b0;
        check("bp_refull", 64'(a_ready), 64'd0);
        d_ready = 1'b1;
        drain();

        // Streaming: alternating Put/Get, one response every cycle
        for (int i = 0; i < 8; i++) begin
            logic [31:0] wd;
            logic [31:0] wa;
            wd = 32'hA5A0_0000 + 32'(i / 2) * 32'h0001_0111;
            wa = 32'h8000_0080 + 32'(4 * (i / 2));
            if (i % 2 == 0) begin
                drive(mk(3'd0, 3'd2, 2'(i % 4), wa, 4'hF, wd, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0));
                exp_q.push_back(rsp(3'd0, 2'(i % 4), 32'h0));
            end else begin
                drive(mk(3'd4, 3'd2, 2'(i % 4), wa, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 32'h0, 1'b0));
                exp_q.push_back(rsp(3'd1, 2'(i % 4), wd));
            end
            check("stream_ready", 64'(a_ready), 64'd1);
            if (i > 0) check("stream_no_bubble", 64'(d_valid), 64'd1);
            @(posedge clock); #1;
        end
        a_valid = 1'b0;
        check("stream_last_valid", 64'(d_valid), 64'd1);
        drain();

        // Async reset with two responses pending
        d_ready = 1'b0;
        send(mk(3'd0, 3'd2, 2'd0, 32'h8000_0040, 4'hF, 32'h5A5A_1234, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0));
        send(mk(3'd0, 3'd2, 2'd1, 32'h8000_0044, 4'hF, 32'h0F0F_0F0F, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0));
        check("pre_reset_full", 64'(a_ready), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_d_valid", 64'(d_valid), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("post_reset_a_ready", 64'(a_ready), 64'd1);
        check("post_reset_d_valid", 64'(d_valid), 64'd0);
        d_ready = 1'b1;
        @(posedge clock); #1;
        send(mk(3'd4, 3'd2, 2'd2, 32'h8000_0040, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 32'h5A5A_1234, 1'b0));
        send(mk(3'd4, 3'd2, 2'd3, 32'h8000_0044, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 32'h0F0F_0F0F, 1'b0));
        send(mk(3'd4, 3'd2, 2'd0, 32'h8000_0010, 4'hF, 32'h0, 1'b0, 3'd1, 1'b0, 32'h99AD_55EF, 1'b0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
